vga_framebuf_dbl_param: RTL and testbench
=========================================

Name: vga_framebuf_dbl_param

Overview:
- Parametrised double-buffered framebuffer controller that sits between the game/render logic and vga_driver.
- Holds two on-chip RAM buffers of virtual pixels, each virtual pixel a 2^SCALE_LOG2 square.
- The VGA scan-out reads the front buffer while the renderer writes the back buffer through a valid/ready port.
- Buffers swap only on request and only at a frame boundary. A hardware clear engine fills the back buffer.

Parameters:
- H_ACTIVE, 640, active VGA width in pixels.
- V_ACTIVE, 480, active VGA height in pixels.
- SCALE_LOG2, 2, log2 of screen pixels per virtual pixel edge. VW = H_ACTIVE>>SCALE_LOG2, VH = V_ACTIVE>>SCALE_LOG2, DEPTH = VW*VH (default 160x120 = 19200).
- COLOR_W, 24, pixel colour width ({R,G,B}).
- ADDR_W, 15, buffer address width; must satisfy 2^ADDR_W >= DEPTH.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  reset, asynchronous, active-low.
- x_pixel  in  10  current scan x from vga_driver.
- y_pixel  in  10  current scan y from vga_driver.
- active_pixels  in  1  vga_driver active-region flag.
- frame_done  in  1  vga_driver end-of-frame level.
- wr_valid  in  1  back-buffer write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_x  in  ADDR_W  virtual x.
- wr_y  in  ADDR_W  virtual y.
- wr_data  in  COLOR_W  pixel colour.
- swap_req  in  1  one-cycle pulse requesting a buffer swap.
- swap_ack  out  1  one-cycle pulse when the swap takes effect.
- clear_req  in  1  one-cycle pulse: fill the back buffer with clear_color.
- clear_color  in  COLOR_W  fill value, sampled on the clear_req cycle.
- busy  out  1  high during any clear.
- front_id  out  1  index of the buffer currently displayed.
- pix_out  out  COLOR_W  colour to VGA_R/G/B.

Behaviour:
- Reset values: wr_ready=0, swap_ack=0, busy=1, front_id=0, pix_out=0, swap pending=0, clear counter=0, state=INIT_CLR.
- States:
  - INIT_CLR: writes 0 to address k of both buffers, k = 0..DEPTH-1, one per cycle. Goes to RUN after k = DEPTH-1, so busy is high for exactly DEPTH cycles.
  - RUN: wr_ready=1, busy=0.
  - CLR: back buffer only, clear_color latched, DEPTH cycles, wr_ready=0, busy=1. Returns to RUN.
- Writes (RUN only): address = wr_y*VW + wr_x, written to the back buffer (buffer !front_id) in the acceptance cycle. If wr_x >= VW or wr_y >= VH, the write is accepted and dropped, with no RAM write.
- clear_req in RUN in the same cycle as an accepted write: the write completes, then CLR starts the next cycle. clear_req outside RUN is ignored.
- Swap:
  - swap_req sets a pending flag at any time; multiple requests collapse into one.
  - A frame boundary is a rising edge of frame_done, detected against a registered copy.
  - On a boundary with pending=1 and state=RUN: front_id toggles, swap_ack pulses for 1 cycle, pending clears.
  - A pending request during INIT_CLR or CLR is held and applied at the first boundary after returning to RUN.
  - A write accepted in the same cycle as the swap targets the pre-swap back buffer.
- Scan-out:
  - Read address = (y_pixel>>SCALE_LOG2)*VW + (x_pixel>>SCALE_LOG2), registered in cycle 0 from the front buffer.
  - RAM output is registered, so pix_out is valid 2 cycles after x/y.
  - active_pixels is delayed 2 cycles; pix_out=0 when the delayed flag is low or state=INIT_CLR.
  - Address is forced to 0 when x_pixel >= H_ACTIVE or y_pixel >= V_ACTIVE.
- Arithmetic: row multiply truncated to ADDR_W. No wrap: the clear counter stops at DEPTH-1.
- Reset mid-operation (any state): immediate return to reset values and a full INIT_CLR restarts.

Optional Feature:
- FB_AUTO_SWAP_EN defined: every frame boundary in RUN is treated as having a pending swap. front_id toggles every frame and swap_ack pulses per frame; swap_req is ignored.
- Undefined: swaps occur only via swap_req as above.

Test Plan:
- Reset release: busy=1 for exactly 19200 cycles, then wr_ready=1 and front_id=0. pix_out=0 throughout the first frame.
- Write (5,3)=24'hFF0000, pulse swap_req, raise frame_done:
  - front_id=1 and a single-cycle swap_ack.
  - Next frame, x=20..23 and y=12..15 give pix_out=24'hFF0000 two cycles after the coordinates; neighbouring pixels give 0.
- Write with wr_x=160 (or wr_y=120): accepted (wr_ready=1), no pixel changes after swap.
- clear_req with clear_color=24'h00FF00 alongside swap_req:
  - busy=1 for 19200 cycles.
  - frame_done edges during CLR do not swap; the swap happens at the first edge after busy falls.
  - Whole screen then reads 24'h00FF00.
- Three swap_req pulses within one frame: exactly one toggle and one swap_ack at the boundary.
- Assert rst mid-CLR at count 5000: all outputs return to reset values; INIT_CLR reruns the full 19200 cycles.
- With FB_AUTO_SWAP_EN: 4 frame_done edges give front_id sequence 1,0,1,0 with no swap_req.

Source files
------------

// File: rtl/vga_framebuf_dbl_param_if.sv
// ---------------------------------------------------------------------------
// vga_framebuf_dbl_param_if
// Render-side port bundle of the double-buffered framebuffer.
//   wr_valid/wr_ready/wr_x/wr_y/wr_data : back-buffer pixel write handshake
//   swap_req/swap_ack                   : buffer swap request / completion pulse
//   clear_req/clear_color/busy          : back-buffer fill request / engine status
//   front_id                            : index of the buffer being scanned out
// master = renderer, slave = framebuffer controller.
// ---------------------------------------------------------------------------
interface vga_framebuf_dbl_param_if #(
  parameter int ADDR_W  = 15,
  parameter int COLOR_W = 24
);
  logic               wr_valid;
  logic               wr_ready;
  logic [ADDR_W-1:0]  wr_x;
  logic [ADDR_W-1:0]  wr_y;
  logic [COLOR_W-1:0] wr_data;
  logic               swap_req;
  logic               swap_ack;
  logic               clear_req;
  logic [COLOR_W-1:0] clear_color;
  logic               busy;
  logic               front_id;

  modport master (
    output wr_valid, wr_x, wr_y, wr_data, swap_req, clear_req, clear_color,
    input  wr_ready, swap_ack, busy, front_id
  );

  modport slave (
    input  wr_valid, wr_x, wr_y, wr_data, swap_req, clear_req, clear_color,
    output wr_ready, swap_ack, busy, front_id
  );
endinterface

// File: rtl/vga_framebuf_dbl_param.sv
// ---------------------------------------------------------------------------
// vga_framebuf_dbl_param
// Double-buffered framebuffer between the renderer and vga_driver. Two on-chip
// buffers of VW x VH virtual pixels (each a 2^SCALE_LOG2 square on screen).
// Scan-out reads the front buffer, the renderer writes the back buffer, and
// buffers swap only at a rising edge of frame_done. A clear engine fills the
// back buffer; after reset both buffers are zero-filled (INIT_CLR).
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   x_pixel, y_pixel  : current scan position from vga_driver
//   active_pixels     : vga_driver active-region flag
//   frame_done        : vga_driver end-of-frame level
//   fb (slave)        : render-side write / swap / clear bundle
//   pix_out           : colour to the DAC, valid 2 cycles after x/y
// Build option: define FB_AUTO_SWAP_EN to swap on every frame boundary in RUN
// and ignore swap_req.
// ---------------------------------------------------------------------------
module vga_framebuf_dbl_param #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int SCALE_LOG2 = 2,
  parameter int COLOR_W    = 24,
  parameter int ADDR_W     = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [9:0]         x_pixel,
  input  logic [9:0]         y_pixel,
  input  logic               active_pixels,
  input  logic               frame_done,
  vga_framebuf_dbl_param_if.slave fb,
  output logic [COLOR_W-1:0] pix_out
);
  localparam int VW    = H_ACTIVE >> SCALE_LOG2;
  localparam int VH    = V_ACTIVE >> SCALE_LOG2;
  localparam int DEPTH = VW * VH;

  localparam logic [ADDR_W-1:0] VW_A   = ADDR_W'(VW);
  localparam logic [ADDR_W-1:0] VH_A   = ADDR_W'(VH);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);
  localparam logic [9:0]        H_A    = 10'(H_ACTIVE);
  localparam logic [9:0]        V_A    = 10'(V_ACTIVE);

  typedef enum logic [1:0] {
    ST_INIT_CLR = 2'd0,
    ST_RUN      = 2'd1,
    ST_CLR      = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic [COLOR_W-1:0] clr_color_q, clr_color_d;
  logic               pend_q, pend_d;
  logic               fd_q;
  logic               front_q, front_d;
  logic               ack_q, ack_d;
  logic               wr_ready_q, wr_ready_d;
  logic               busy_q, busy_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic               act_q;
  logic [COLOR_W-1:0] pix_q, pix_d;

  logic [COLOR_W-1:0] mem0_q [DEPTH];
  logic [COLOR_W-1:0] mem1_q [DEPTH];

  logic               we0_s, we1_s;
  logic [ADDR_W-1:0]  waddr_s;
  logic [COLOR_W-1:0] wdata_s;
  logic               wr_acc_s, wr_inr_s;
  logic [ADDR_W-1:0]  wr_addr_s;
  logic [ADDR_W-1:0]  vx_s, vy_s;
  logic               boundary_s, swap_want_s, do_swap_s;

  // Mode sequencing: zero-fill after reset, run, back-buffer clear.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    clr_color_d = clr_color_q;
    case (state_q)
      ST_INIT_CLR, ST_CLR: begin
        // Counter saturates at the last address; leaving here resets it.
        if (cnt_q == LAST_A) begin
          state_d = ST_RUN;
          cnt_d   = {ADDR_W{1'b0}};
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      ST_RUN: begin
        if (fb.clear_req) begin
          state_d     = ST_CLR;
          cnt_d       = {ADDR_W{1'b0}};
          clr_color_d = fb.clear_color;
        end else begin
          cnt_d = {ADDR_W{1'b0}};
        end
      end
      default: begin
        state_d = ST_INIT_CLR;
        cnt_d   = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Renderer write decode: out-of-range coordinates are accepted but dropped.
  always_comb begin
    wr_acc_s  = fb.wr_valid & wr_ready_q;
    wr_inr_s  = (fb.wr_x < VW_A) && (fb.wr_y < VH_A);
    wr_addr_s = fb.wr_y * VW_A + fb.wr_x;
  end

  // RAM write port: fill engine in INIT_CLR/CLR, renderer writes in RUN.
  always_comb begin
    we0_s   = 1'b0;
    we1_s   = 1'b0;
    waddr_s = cnt_q;
    wdata_s = {COLOR_W{1'b0}};
    case (state_q)
      ST_INIT_CLR: begin
        we0_s = 1'b1;
        we1_s = 1'b1;
      end
      ST_CLR: begin
        // Back buffer is the one not displayed; no swap can occur in CLR.
        we0_s   = front_q;
        we1_s   = ~front_q;
        wdata_s = clr_color_q;
      end
      ST_RUN: begin
        if (wr_acc_s && wr_inr_s) begin
          we0_s   = front_q;
          we1_s   = ~front_q;
          waddr_s = wr_addr_s;
          wdata_s = fb.wr_data;
        end else begin
          we0_s = 1'b0;
          we1_s = 1'b0;
        end
      end
      default: begin
        we0_s = 1'b0;
        we1_s = 1'b0;
      end
    endcase
  end

  // Swap control: requests latch until a frame boundary seen in RUN.
  always_comb begin
    boundary_s = frame_done & ~fd_q;
`ifdef FB_AUTO_SWAP_EN
    swap_want_s = 1'b1;
    do_swap_s   = boundary_s & swap_want_s & (state_q == ST_RUN);
    pend_d      = 1'b0;
`else
    swap_want_s = pend_q;
    do_swap_s   = boundary_s & swap_want_s & (state_q == ST_RUN);
    pend_d      = fb.swap_req | (pend_q & ~do_swap_s);
`endif
    front_d    = front_q ^ do_swap_s;
    ack_d      = do_swap_s;
    wr_ready_d = (state_d == ST_RUN);
    busy_d     = (state_d != ST_RUN);
  end

  // Scan-out: virtual address from the scan position, then registered read.
  always_comb begin
    vx_s = ADDR_W'(x_pixel >> SCALE_LOG2);
    vy_s = ADDR_W'(y_pixel >> SCALE_LOG2);
    if ((x_pixel < H_A) && (y_pixel < V_A)) begin
      rd_addr_d = vy_s * VW_A + vx_s;
    end else begin
      rd_addr_d = {ADDR_W{1'b0}};
    end
    if (act_q && (state_q != ST_INIT_CLR)) begin
      pix_d = front_q ? mem1_q[rd_addr_q] : mem0_q[rd_addr_q];
    end else begin
      pix_d = {COLOR_W{1'b0}};
    end
  end

  // Control and pipeline registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_INIT_CLR;
      cnt_q       <= {ADDR_W{1'b0}};
      clr_color_q <= {COLOR_W{1'b0}};
      pend_q      <= 1'b0;
      fd_q        <= 1'b0;
      front_q     <= 1'b0;
      ack_q       <= 1'b0;
      wr_ready_q  <= 1'b0;
      busy_q      <= 1'b1;
      rd_addr_q   <= {ADDR_W{1'b0}};
      act_q       <= 1'b0;
      pix_q       <= {COLOR_W{1'b0}};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      clr_color_q <= clr_color_d;
      pend_q      <= pend_d;
      fd_q        <= frame_done;
      front_q     <= front_d;
      ack_q       <= ack_d;
      wr_ready_q  <= wr_ready_d;
      busy_q      <= busy_d;
      rd_addr_q   <= rd_addr_d;
      act_q       <= active_pixels;
      pix_q       <= pix_d;
    end
  end

  // Buffer 0 storage.
  always_ff @(posedge clk) begin
    if (we0_s) begin
      mem0_q[waddr_s] <= wdata_s;
    end
  end

  // Buffer 1 storage.
  always_ff @(posedge clk) begin
    if (we1_s) begin
      mem1_q[waddr_s] <= wdata_s;
    end
  end

  assign fb.wr_ready = wr_ready_q;
  assign fb.swap_ack = ack_q;
  assign fb.busy     = busy_q;
  assign fb.front_id = front_q;
  assign pix_out     = pix_q;

endmodule

// File: tb/tb_vga_framebuf_dbl_param.sv
module tb_vga_framebuf_dbl_param;
  localparam int VW    = 160;
  localparam int VH    = 120;
  localparam int DEPTH = VW * VH;
`ifdef FB_AUTO_SWAP_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [9:0]  x_pixel, y_pixel;
  logic        active_pixels, frame_done;
  logic [23:0] pix_out;

  int checks = 0;
  int errors = 0;

  vga_framebuf_dbl_param_if #(.ADDR_W(15), .COLOR_W(24)) fb_if ();

  vga_framebuf_dbl_param dut (
    .clk          (clk),
    .rst          (rst),
    .x_pixel      (x_pixel),
    .y_pixel      (y_pixel),
    .active_pixels(active_pixels),
    .frame_done   (frame_done),
    .fb           (fb_if),
    .pix_out      (pix_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [23:0] m_mem [2][DEPTH];
  bit        m_run, m_init, m_front, m_pend, m_fd, m_ack, m_act1;
  int        m_busy_left, m_addr1;
  bit [23:0] m_pix;

  function automatic int vaddr(input int x, input int y);
    if (x >= 640 || y >= 480) return 0;
    return (y / 4) * VW + (x / 4);
  endfunction

  task automatic m_fill(input int b, input bit [23:0] c);
    for (int i = 0; i < DEPTH; i++) m_mem[b][i] = c;
  endtask

  task automatic m_reset();
    m_fill(0, 24'h0);
    m_fill(1, 24'h0);
    m_run = 1'b0; m_init = 1'b1; m_busy_left = DEPTH;
    m_front = 1'b0; m_pend = 1'b0; m_fd = 1'b0; m_ack = 1'b0;
    m_act1 = 1'b0; m_addr1 = 0; m_pix = 24'h0;
  endtask

  task automatic m_step();
    bit [23:0] np;
    bit bnd, sw;
    np = (m_act1 && !m_init) ? m_mem[int'(m_front)][m_addr1] : 24'h0;
    m_addr1 = vaddr(int'(x_pixel), int'(y_pixel));
    m_act1  = active_pixels;
    m_pix   = np;
    bnd  = frame_done && !m_fd;
    m_fd = frame_done;
    sw   = bnd && m_run && (AUTO || m_pend);
    if (m_run && fb_if.wr_valid && int'(fb_if.wr_x) < VW && int'(fb_if.wr_y) < VH)
      m_mem[int'(!m_front)][int'(fb_if.wr_y) * VW + int'(fb_if.wr_x)] = fb_if.wr_data;
    m_pend = AUTO ? 1'b0 : (fb_if.swap_req || (m_pend && !sw));
    if (sw) m_front = !m_front;
    m_ack = sw;
    if (m_run) begin
      if (fb_if.clear_req) begin
        m_run = 1'b0;
        m_busy_left = DEPTH;
        m_fill(int'(!m_front), fb_if.clear_color);
      end
    end else begin
      m_busy_left--;
      if (m_busy_left == 0) begin
        m_run  = 1'b1;
        m_init = 1'b0;
      end
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(posedge clk) begin
    if (!rst) m_reset();
    else      m_step();
    #1;
    chk("cyc_wr_ready", fb_if.wr_ready, m_run);
    chk("cyc_busy",     fb_if.busy,     !m_run);
    chk("cyc_swap_ack", fb_if.swap_ack, m_ack);
    chk("cyc_front_id", fb_if.front_id, m_front);
    chk("cyc_pix_out",  pix_out,        m_pix);
  end

  initial begin
    #1200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic wr(input int x, input int y, input bit [23:0] d);
    @(negedge clk);
    fb_if.wr_x = 15'(x); fb_if.wr_y = 15'(y); fb_if.wr_data = d; fb_if.wr_valid = 1'b1;
    chk("wr_ready_at_accept", fb_if.wr_ready, 1);
    @(negedge clk);
    fb_if.wr_valid = 1'b0;
  endtask

  task automatic pulse_swap();
    @(negedge clk); fb_if.swap_req = 1'b1;
    @(negedge clk); fb_if.swap_req = 1'b0;
  endtask

  task automatic frame_edge(output int acks);
    @(negedge clk); frame_done = 1'b1;
    acks = 0;
    repeat (6) begin
      @(negedge clk); frame_done = 1'b0;
      acks += int'(fb_if.swap_ack);
    end
  endtask

  task automatic probe(input int x, input int y, input bit [23:0] exp, input string nm);
    @(negedge clk);
    x_pixel = 10'(x); y_pixel = 10'(y); active_pixels = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk(nm, pix_out, exp);
  endtask

  // Counts clock edges until busy falls; optionally pulses frame_done meanwhile.
  task automatic wait_busy(input bit pulses, output int n);
    n = 0;
    while (fb_if.busy && n < 40000) begin
      @(posedge clk); #1;
      n++;
      frame_done = pulses && (n % 3000 == 0) && (n <= 9000);
      if (pulses && n == 9500) chk("no_swap_during_clr", fb_if.front_id, 0);
    end
    frame_done = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_wr_ready"}, fb_if.wr_ready, 0);
    chk({tag, "_busy"},     fb_if.busy,     1);
    chk({tag, "_swap_ack"}, fb_if.swap_ack, 0);
    chk({tag, "_front_id"}, fb_if.front_id, 0);
    chk({tag, "_pix_out"},  pix_out,        0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n, acks;
    rst = 1'b0;
    x_pixel = 10'd0; y_pixel = 10'd0; active_pixels = 1'b1; frame_done = 1'b0;
    fb_if.wr_valid = 1'b0; fb_if.wr_x = 15'd0; fb_if.wr_y = 15'd0; fb_if.wr_data = 24'h0;
    fb_if.swap_req = 1'b0; fb_if.clear_req = 1'b0; fb_if.clear_color = 24'h0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b1;
    wait_busy(1'b0, n);
    chk("init_busy_cycles", n, DEPTH);
    chk("init_wr_ready", fb_if.wr_ready, 1);
    chk("init_front_id", fb_if.front_id, 0);

`ifdef FB_AUTO_SWAP_EN
    for (int i = 0; i < 4; i++) begin
      frame_edge(acks);
      chk("auto_front_id", fb_if.front_id, (i % 2 == 0) ? 1 : 0);
      chk("auto_acks", acks, 1);
    end
`else
    // Single pixel, swap at the next boundary.
    wr(5, 3, 24'hFF0000);
    pulse_swap();
    frame_edge(acks);
    chk("swap1_front_id", fb_if.front_id, 1);
    chk("swap1_acks", acks, 1);
    for (int y = 12; y < 16; y++)
      for (int x = 20; x < 24; x++)
        probe(x, y, 24'hFF0000, "red_block");
    probe(19, 12, 24'h0, "red_left");
    probe(24, 12, 24'h0, "red_right");
    probe(20, 11, 24'h0, "red_above");
    probe(20, 16, 24'h0, "red_below");

    // Out-of-range writes are accepted and dropped.
    wr(0, 0, 24'h0000AA);
    wr(160, 0, 24'h123456);
    wr(3, 120, 24'h654321);
    pulse_swap();
    frame_edge(acks);
    chk("swap2_front_id", fb_if.front_id, 0);
    probe(0, 0, 24'h0000AA, "blue_origin");
    probe(3, 3, 24'h0000AA, "blue_origin_sub");
    probe(640, 5, 24'h0000AA, "x_oob_addr0");
    probe(8, 480, 24'h0000AA, "y_oob_addr0");
    probe(0, 4, 24'h0, "dropped_wr_x160");
    probe(20, 12, 24'h0, "red_in_back");

    // Clear with a concurrent swap request; swap waits until the clear ends.
    @(negedge clk);
    fb_if.clear_req = 1'b1; fb_if.clear_color = 24'h00FF00; fb_if.swap_req = 1'b1;
    @(posedge clk); #1;
    fb_if.clear_req = 1'b0; fb_if.swap_req = 1'b0; fb_if.clear_color = 24'h0;
    chk("clr_wr_ready", fb_if.wr_ready, 0);
    wait_busy(1'b1, n);
    chk("clr_busy_cycles", n, DEPTH);
    chk("clr_end_front_id", fb_if.front_id, 0);
    frame_edge(acks);
    chk("swap3_front_id", fb_if.front_id, 1);
    chk("swap3_acks", acks, 1);
    for (int y = 0; y < 480; y += 16)
      for (int x = 0; x < 640; x += 16)
        probe(x, y, 24'h00FF00, "green_screen");
    probe(639, 479, 24'h00FF00, "green_corner");

    // Three requests collapse; write in swap cycle targets pre-swap back.
    pulse_swap();
    repeat (3) @(negedge clk);
    pulse_swap();
    pulse_swap();
    repeat (2) @(negedge clk);
    @(negedge clk);
    frame_done = 1'b1;
    fb_if.wr_valid = 1'b1; fb_if.wr_x = 15'd1; fb_if.wr_y = 15'd1; fb_if.wr_data = 24'h111111;
    @(negedge clk);
    frame_done = 1'b0; fb_if.wr_valid = 1'b0;
    acks = int'(fb_if.swap_ack);
    chk("swap4_front_id", fb_if.front_id, 0);
    repeat (5) begin
      @(negedge clk);
      acks += int'(fb_if.swap_ack);
    end
    chk("swap4_acks", acks, 1);
    probe(4, 4, 24'h111111, "swap_cycle_write");
    probe(0, 0, 24'h0000AA, "front0_origin");
    frame_edge(acks);
    chk("no_req_front_id", fb_if.front_id, 0);
    chk("no_req_acks", acks, 0);

    // Reset in the middle of a clear.
    @(negedge clk);
    fb_if.clear_req = 1'b1; fb_if.clear_color = 24'h0000FF;
    @(posedge clk); #1;
    fb_if.clear_req = 1'b0;
    repeat (5000) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_vals("midclr_reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_busy(1'b0, n);
    chk("reinit_busy_cycles", n, DEPTH);
    chk("reinit_front_id", fb_if.front_id, 0);
    probe(20, 12, 24'h0, "reinit_pixel");
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
